stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Parametrised stopwatch timebase for the calculator/stopwatch display path.
//  Divides clk down to a fractional-second tick and counts fraction and whole seconds.
//  Provides start/stop/clear control, a lap (display freeze) function and a wrap pulse.
//  Feeds the display/BCD stage, replacing the fixed 1 Hz seconds counter.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency in Hz
//  TICK_HZ  100         fraction ticks per second (100 = centiseconds); CLK_HZ % TICK_HZ == 0
//  SEC_MAX  999         last seconds value before wrap to 0
//  SEC_W    10          width of seconds outputs; 2**SEC_W > SEC_MAX
//  FRAC_W   7           width of fraction outputs; 2**FRAC_W >= TICK_HZ
// PORTS
//  clk       in   1       system clock, all logic on rising edge
//  rst       in   1       synchronous active-high reset
//  start     in   1       one-cycle pulse: begin/resume counting
//  stop      in   1       one-cycle pulse: pause counting
//  clear     in   1       one-cycle pulse: zero counts, return to IDLE
//  lap       in   1       one-cycle pulse: toggle display freeze
//  sec_out   out  SEC_W   displayed whole seconds
//  frac_out  out  FRAC_W  displayed fraction, 0..TICK_HZ-1
//  running   out  1       1 while in RUN
//  lap_hold  out  1       1 while display is frozen
//  wrap      out  1       one-cycle pulse when seconds wraps SEC_MAX -> 0
// BEHAVIOUR
//  - DIV = CLK_HZ/TICK_HZ. Prescaler counts 0..DIV-1; tick asserted in the cycle it equals DIV-1.
//  - Prescaler advances only in RUN; in PAUSED it holds its value (resume stays phase-accurate).
//  - FSM: IDLE (counts zero) / RUN / PAUSED. Reset -> IDLE.
//    IDLE: start -> RUN. RUN: stop -> PAUSED. PAUSED: start -> RUN.
//    Any state: clear -> IDLE. Start in RUN and stop in IDLE/PAUSED are ignored.
//  - Control priority in one cycle: rst > clear > stop > start; lap is evaluated independently.
//  - On tick in RUN: frac+1; if frac==TICK_HZ-1 then frac->0 and sec+1;
//    if also sec==SEC_MAX then sec->0 and wrap=1 in the following cycle (registered, 1 cycle).
//  - Stop coinciding with a tick: the tick is applied, then state -> PAUSED.
//  - Clear/rst: prescaler, frac, sec -> 0; lap_hold -> 0; wrap -> 0; state -> IDLE.
//  - Display: sec_out/frac_out are registers loaded from the internal counts every cycle while
//    lap_hold=0 (1-cycle latency from count update to output); held while lap_hold=1.
//  - lap pulse toggles lap_hold in RUN or PAUSED; ignored in IDLE. Internal counting is unaffected
//    by lap_hold; releasing shows the live count on the next cycle.
//  - running = (state==RUN), registered with the state.
//  - Reset values: sec_out=0, frac_out=0, running=0, lap_hold=0, wrap=0.
//  - Counts never exceed SEC_MAX / TICK_HZ-1; no out-of-range value is ever visible.
// TESTING (bench params CLK_HZ=10, TICK_HZ=5, SEC_MAX=3 -> DIV=2)
//  1 rst, start; run 10 cycles -> frac_out steps 0..4 every 2 clk, then sec_out=1, frac_out=0.
//  2 run to sec=3,frac=4, next tick -> sec_out=0, frac_out=0, wrap high exactly 1 cycle.
//  3 start, 3 cycles, stop, wait 20, start -> prescaler resumes mid-count; no lost/extra tick.
//  4 in RUN pulse lap at sec=1 -> outputs frozen while counts advance; lap again -> live value.
//  5 clear and stop same cycle during RUN with lap_hold=1 -> IDLE, all outputs 0, running=0.
//  6 rst asserted mid-RUN -> next cycle all outputs 0, state IDLE; start/stop in IDLE no-op.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: stopwatch timebase for the calculator/stopwatch display path.
// Divides clk down to a fractional-second tick and counts fraction and whole
// seconds. It has start/stop/clear control, a lap (display freeze) function
// and a one-cycle wrap pulse when the seconds count rolls over.
//
// Ports
//   clk       in   1       system clock, rising edge
//   rst       in   1       synchronous active-high reset
//   start     in   1       pulse: begin/resume counting
//   stop      in   1       pulse: pause counting
//   clear     in   1       pulse: zero counts, return to IDLE
//   lap       in   1       pulse: toggle display freeze (RUN/PAUSED only)
//   sec_out   out  SEC_W   displayed whole seconds
//   frac_out  out  FRAC_W  displayed fraction, 0..TICK_HZ-1
//   running   out  1       high while in RUN
//   lap_hold  out  1       high while the display is frozen
//   wrap      out  1       one-cycle pulse after seconds wrap SEC_MAX -> 0
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100,
  parameter int unsigned SEC_MAX = 999,
  parameter int unsigned SEC_W   = 10,
  parameter int unsigned FRAC_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              lap,
  output logic [SEC_W-1:0]  sec_out,
  output logic [FRAC_W-1:0] frac_out,
  output logic              running,
  output logic              lap_hold,
  output logic              wrap
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
  localparam logic [FRAC_W-1:0] FRAC_LAST = FRAC_W'(TICK_HZ - 1);
  localparam logic [FRAC_W-1:0] FRAC_ONE  = FRAC_W'(1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0]  SEC_ONE   = SEC_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  state_t             state;
  logic [PRE_W-1:0]   pre;
  logic [FRAC_W-1:0]  frac;
  logic [SEC_W-1:0]   sec;
  logic               tick;

  // The prescaler only moves in RUN, so a tick can only occur in RUN.
  always_comb begin
    tick = (state == RUN) && (pre == PRE_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      // Clear shares the reset path; the display registers are zeroed here
      // too so the panel blanks immediately, even with lap_hold set.
      state    <= IDLE;
      pre      <= '0;
      frac     <= '0;
      sec      <= '0;
      sec_out  <= '0;
      frac_out <= '0;
      running  <= 1'b0;
      lap_hold <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;

      // In PAUSED the prescaler keeps its phase so a resume is tick-accurate.
      if (state == RUN) begin
        pre <= tick ? '0 : pre + PRE_ONE;
      end

      // The tick uses the current state, so a stop in the same cycle still
      // lets this tick land before the move to PAUSED.
      if (tick) begin
        if (frac == FRAC_LAST) begin
          frac <= '0;
          if (sec == SEC_LAST) begin
            sec  <= '0;
            wrap <= 1'b1;
          end else begin
            sec <= sec + SEC_ONE;
          end
        end else begin
          frac <= frac + FRAC_ONE;
        end
      end

      // Stop outranks start: a cycle with both never moves the FSM to RUN.
      if (stop) begin
        if (state == RUN) begin
          state   <= PAUSED;
          running <= 1'b0;
        end
      end else if (start && (state != RUN)) begin
        state   <= RUN;
        running <= 1'b1;
      end

      if (lap && (state != IDLE)) begin
        lap_hold <= ~lap_hold;
      end

      if (!lap_hold) begin
        sec_out  <= sec;
        frac_out <= frac;
      end
    end
  end

endmodule
